phy_rx_lanes: RTL and testbench
===============================

Name: phy_rx_lanes

Overview:
Parametrised successor to the fixed 4-lane, 8-bit PHY receiver, running in a single clock domain. Bits arrive serially, one per clk_32f cycle, MSB first. The block finds byte alignment by hunting for the COM symbol, confirms it with COM_COUNT consecutive COMs, then deserializes data bytes and distributes them round-robin across LANES output lanes. Internal bit/byte counters replace the divided-clock tree.

Parameters:
W, 8, symbol width in bits (W >= 4)
LANES, 4, number of output lanes (>= 1)
COM, 8'hBC, alignment/comma symbol (W bits)
IDL, 8'h7C, idle filler symbol (W bits)
COM_COUNT, 4, consecutive aligned COMs required to declare lock (>= 1)
LOSS_LIMIT, 64, byte times without a COM before lock is dropped (used only with the optional feature)

Ports:
clk_32f  in  1  serial bit clock; single clock for the whole block
default_values  in  1  synchronous active-high reset
data_in  in  1  serial bit, sampled every rising clk_32f edge, MSB first
active  out  1  lock achieved; data path enabled
valid  out  1  one-cycle pulse per delivered data byte (OR of valid_out)
data_out  out  LANES*W  lane L occupies bits [L*W +: W]; holds its last byte
valid_out  out  LANES  one-cycle pulse on the lane just written
data_hexa  out  W  last delivered data byte, any lane

Behaviour:
- Reset is synchronous, active-high, and applies whenever asserted, including mid-stream. Reset values: all outputs 0, shift register 0, state SEARCH, counters 0, lane_ptr 0.
- Shift register sr[W-1:0] shifts data_in into the LSB every cycle, in all states.
- SEARCH: each cycle, compare the post-shift sr with COM. On match: bit_cnt cleared (byte boundary), com_cnt = 1, go to ALIGN. If COM_COUNT == 1, go directly to ACTIVE.
- Byte boundary: W cycles after the previous boundary; bit_cnt counts 0..W-1 and wraps.
- ALIGN, at a boundary:
  - sr == COM: com_cnt++. When it reaches COM_COUNT, go to ACTIVE; active = 1 from the next cycle.
  - any other byte: go to SEARCH, com_cnt = 0. The bit hunt resumes on the following cycle.
- ACTIVE, at a boundary:
  - COM: lane_ptr = 0 (lane resync); no valid.
  - IDL: discarded; no valid.
  - any other byte: data. Write data_out lane lane_ptr, pulse valid_out[lane_ptr] and valid, set data_hexa, then lane_ptr = (lane_ptr + 1) mod LANES.
- Latency: the last bit of a byte is sampled at edge k; data_out, valid_out, valid and data_hexa update at edge k+1. Pulses last exactly one cycle.
- Without the optional feature, ACTIVE is held until reset.
- Only boundary bytes are decoded; COM patterns straddling a boundary are ignored once aligned.
- LANES == 1: lane_ptr is constant 0.

Optional Feature:
PHY_RX_LOSS_EN:
- Defined: loss_cnt increments at each ACTIVE boundary and clears on any COM boundary byte. When a boundary arrives with loss_cnt == LOSS_LIMIT-1 and a non-COM byte, the block goes to SEARCH: active = 0 next cycle, com_cnt = 0, lane_ptr = 0. data_out and data_hexa retain their values. The offending byte is still delivered if it is data.
- Undefined: no loss counter; ACTIVE is sticky until reset.

Decomposition:
- Package phy_rx_pkg: state encoding (SEARCH, ALIGN, ACTIVE), default COM/IDL constants, and the clog2-based widths for bit_cnt, com_cnt, lane_ptr and loss_cnt.
- One natural sub-module, phy_rx_deser: shift register plus bit_cnt, producing the sr value and a boundary strobe.
- The FSM and lane distributor stay in phy_rx_lanes.

Test Plan:
- Reset: hold default_values 3 cycles with random data_in -> all outputs 0. Release -> active stays 0 until 4 COMs are received.
- Alignment at arbitrary offset: 3 random bits, then 4×0xBC -> active rises 1 cycle after the 4th COM's last bit. Then bytes 0x11, 0x22, 0x33, 0x44, 0x55 -> lanes 0..3 = 11/22/33/44, lane 0 = 55, valid pulses 5 times, data_hexa = 0x55.
- Failed lock: 3×COM, 0x00, then 4×COM -> active stays 0 through the 0x00. It rises only after the second COM run completes.
- Filler and resync: once ACTIVE, send 0xA1, 0x7C, 0xA2, 0xBC, 0xA3 -> A1 to lane 0, IDL dropped, A2 to lane 1, COM resets pointer, A3 to lane 0. valid_out sequence is 0001, 0010, 0001.
- Reset mid-stream: assert default_values between data bytes -> next cycle all outputs 0 and lane_ptr 0. A fresh lock is required.
- With PHY_RX_LOSS_EN and LOSS_LIMIT = 8: 8 data bytes with no COM -> active falls 1 cycle after the 8th byte's last bit, and the 8th byte is still delivered. Without the macro -> active remains 1.

Source files
------------

// File: rtl/phy_rx_pkg.sv
// Shared definitions for the serial PHY receiver: FSM states, default symbols, counter widths.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package phy_rx_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,   // bit-by-bit hunt for COM
        ST_ALIGN  = 2'd1,   // byte boundary found, confirming with further COMs
        ST_ACTIVE = 2'd2    // locked, delivering data bytes to lanes
    } state_t;

    localparam logic [7:0] COM_DEF = 8'hBC;
    localparam logic [7:0] IDL_DEF = 8'h7C;

    // Width of a counter holding 0..n-1; never narrower than one bit so that
    // degenerate configurations (e.g. a single lane) still get a legal vector.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Counter widths used by the receiver.
    function automatic int bit_cnt_w(input int w);
        return cnt_w(w);
    endfunction

    function automatic int com_cnt_w(input int com_count);
        return cnt_w(com_count + 1);
    endfunction

    function automatic int lane_ptr_w(input int lanes);
        return cnt_w(lanes);
    endfunction

    function automatic int loss_cnt_w(input int loss_limit);
        return cnt_w(loss_limit);
    endfunction

endpackage

// File: rtl/phy_rx_deser.sv
// Serial-to-parallel shifter with a free-running bit counter marking byte boundaries.
// Latency: o_sr reflects the bit sampled on the previous edge; o_bnd is high while o_sr holds a full aligned symbol.
// Backpressure: none; one bit is consumed every clock.
// Ports: i_clk clock, i_rst sync active-high reset, i_bit serial input (MSB first),
//        i_sync restarts the symbol count (current o_sr is treated as a boundary symbol),
//        o_sr current shift register, o_bnd boundary strobe.
module phy_rx_deser
    import phy_rx_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_bit,
    input  logic         i_sync,
    output logic [W-1:0] o_sr,
    output logic         o_bnd
);

    localparam int BW = bit_cnt_w(W);

    logic [W-1:0]  r_sr;
    logic [BW-1:0] r_bit_cnt;

    // r_bit_cnt counts bits of the next symbol already shifted in, minus one.
    // Clearing it on i_sync means the symbol currently in r_sr is a boundary,
    // so the next boundary appears exactly W shifts later.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sr      <= '0;
            r_bit_cnt <= '0;
        end else begin
            r_sr <= {r_sr[W-2:0], i_bit};
            if (i_sync || (r_bit_cnt == BW'(W - 1))) begin
                r_bit_cnt <= '0;
            end else begin
                r_bit_cnt <= r_bit_cnt + BW'(1);
            end
        end
    end

    assign o_sr  = r_sr;
    assign o_bnd = (r_bit_cnt == BW'(W - 1));

endmodule

// File: rtl/phy_rx_lanes.sv
// Serial PHY receiver: hunts COM alignment, confirms lock, deserializes and stripes data bytes round-robin over LANES lanes.
// Latency: outputs update one clk_32f edge after the edge sampling a symbol's last bit; valid pulses last one cycle.
// Backpressure: none; the serial stream is never stalled, bytes are delivered as they complete.
// Ports: clk_32f bit clock, default_values sync active-high reset, data_in serial bit (MSB first);
//        active lock flag, valid/valid_out delivery pulses, data_out lane bytes (lane L at [L*W +: W]),
//        data_hexa last delivered byte.
// Optional macro PHY_RX_LOSS_EN: drop lock after LOSS_LIMIT boundary symbols without a COM.
module phy_rx_lanes
    import phy_rx_pkg::*;
#(
    parameter int           W          = 8,
    parameter int           LANES      = 4,
    parameter logic [W-1:0] COM        = W'(COM_DEF),
    parameter logic [W-1:0] IDL        = W'(IDL_DEF),
    parameter int           COM_COUNT  = 4,
    parameter int           LOSS_LIMIT = 64
) (
    input  logic                 clk_32f,
    input  logic                 default_values,
    input  logic                 data_in,
    output logic                 active,
    output logic                 valid,
    output logic [LANES*W-1:0]   data_out,
    output logic [LANES-1:0]     valid_out,
    output logic [W-1:0]         data_hexa
);

    localparam int CW  = com_cnt_w(COM_COUNT);
    localparam int LW  = lane_ptr_w(LANES);
    localparam int LSW = loss_cnt_w(LOSS_LIMIT);

    generate
        if (W < 4 || LANES < 1 || COM_COUNT < 1 || LOSS_LIMIT < 1) begin : g_bad_params
            $error("phy_rx_lanes: illegal parameter set");
        end
    endgenerate

    logic [W-1:0]       w_sr;
    logic               w_bnd;
    logic               w_sync;
    logic               w_is_com;
    logic               w_is_idl;

    state_t             r_state,    w_state_nx;
    logic [CW-1:0]      r_com_cnt,  w_com_cnt_nx;
    logic [LW-1:0]      r_lane,     w_lane_nx;
    logic [LSW-1:0]     r_loss,     w_loss_nx;
    logic [LANES*W-1:0] r_data_out, w_data_out_nx;
    logic [LANES-1:0]   r_valid_out, w_valid_out_nx;
    logic [W-1:0]       r_data_hexa, w_data_hexa_nx;
    logic               r_valid;

    phy_rx_deser #(.W(W)) u_deser (
        .i_clk  (clk_32f),
        .i_rst  (default_values),
        .i_bit  (data_in),
        .i_sync (w_sync),
        .o_sr   (w_sr),
        .o_bnd  (w_bnd)
    );

    assign w_is_com = (w_sr == COM);
    assign w_is_idl = (w_sr == IDL);

    always_ff @(posedge clk_32f) begin
        if (default_values) begin
            r_state     <= ST_SEARCH;
            r_com_cnt   <= '0;
            r_lane      <= '0;
            r_loss      <= '0;
            r_data_out  <= '0;
            r_valid_out <= '0;
            r_data_hexa <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_com_cnt   <= w_com_cnt_nx;
            r_lane      <= w_lane_nx;
            r_loss      <= w_loss_nx;
            r_data_out  <= w_data_out_nx;
            r_valid_out <= w_valid_out_nx;
            r_data_hexa <= w_data_hexa_nx;
            r_valid     <= |w_valid_out_nx;
        end
    end

    always_comb begin
        w_state_nx     = r_state;
        w_com_cnt_nx   = r_com_cnt;
        w_lane_nx      = r_lane;
        // The loss counter only means something while locked.
        w_loss_nx      = (r_state == ST_ACTIVE) ? r_loss : '0;
        w_data_out_nx  = r_data_out;
        w_valid_out_nx = '0;
        w_data_hexa_nx = r_data_hexa;
        w_sync         = 1'b0;

        case (r_state)
            ST_SEARCH: begin
                // Every bit position is a candidate until a COM is seen.
                if (w_is_com) begin
                    w_sync       = 1'b1;
                    w_com_cnt_nx = CW'(1);
                    w_state_nx   = (COM_COUNT == 1) ? ST_ACTIVE : ST_ALIGN;
                end
            end

            ST_ALIGN: begin
                if (w_bnd) begin
                    if (w_is_com) begin
                        w_com_cnt_nx = r_com_cnt + CW'(1);
                        if (r_com_cnt == CW'(COM_COUNT - 1)) begin
                            w_state_nx = ST_ACTIVE;
                        end
                    end else begin
                        w_state_nx   = ST_SEARCH;
                        w_com_cnt_nx = '0;
                    end
                end
            end

            ST_ACTIVE: begin
                if (w_bnd) begin
                    if (w_is_com) begin
                        w_lane_nx = '0;
                    end else if (!w_is_idl) begin
                        for (int l = 0; l < LANES; l++) begin
                            if (r_lane == LW'(l)) begin
                                w_data_out_nx[l*W +: W] = w_sr;
                                w_valid_out_nx[l]       = 1'b1;
                            end
                        end
                        w_data_hexa_nx = w_sr;
                        w_lane_nx = (r_lane == LW'(LANES - 1)) ? '0 : r_lane + LW'(1);
                    end
`ifdef PHY_RX_LOSS_EN
                    // Lock is dropped on the boundary that completes LOSS_LIMIT
                    // symbols without a COM; a data byte there is still delivered above.
                    if (w_is_com) begin
                        w_loss_nx = '0;
                    end else if (r_loss == LSW'(LOSS_LIMIT - 1)) begin
                        w_state_nx   = ST_SEARCH;
                        w_com_cnt_nx = '0;
                        w_lane_nx    = '0;
                        w_loss_nx    = '0;
                    end else begin
                        w_loss_nx = r_loss + LSW'(1);
                    end
`endif
                end
            end

            default: begin
                w_state_nx   = ST_SEARCH;
                w_com_cnt_nx = '0;
            end
        endcase
    end

    assign active    = (r_state == ST_ACTIVE);
    assign valid     = r_valid;
    assign data_out  = r_data_out;
    assign valid_out = r_valid_out;
    assign data_hexa = r_data_hexa;

endmodule

// File: tb/tb_phy_rx_lanes.sv
module tb_phy_rx_lanes;

    localparam int W     = 8;
    localparam int LANES = 4;
    localparam int CC    = 4;
    localparam int LL    = 8;
    localparam logic [7:0] COM = 8'hBC;
    localparam logic [7:0] IDL = 8'h7C;
    localparam int NV    = 24;

    logic                 clk_32f = 1'b0;
    logic                 default_values = 1'b1;
    logic                 data_in = 1'b0;
    logic                 active;
    logic                 valid;
    logic [LANES*W-1:0]   data_out;
    logic [LANES-1:0]     valid_out;
    logic [W-1:0]         data_hexa;

    always #5 clk_32f = ~clk_32f;

    phy_rx_lanes #(
        .W(W), .LANES(LANES), .COM(COM), .IDL(IDL), .COM_COUNT(CC), .LOSS_LIMIT(LL)
    ) dut (
        .clk_32f        (clk_32f),
        .default_values (default_values),
        .data_in        (data_in),
        .active         (active),
        .valid          (valid),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .data_hexa      (data_hexa)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Works on the received bit history: t bits since reset, m_win the last W
    // of them, m_ref the index of the last bit of the symbol that set alignment.
    // Symbol boundaries are simply every W bits after m_ref.
    int               m_mode;   // 0 hunting, 1 confirming, 2 locked
    int               t;
    int               m_ref;
    int               m_coms;
    int               m_lane;
    int               m_loss;
    logic [W-1:0]     m_win;
    logic [LANES*W-1:0] e_do;
    logic [LANES-1:0] e_vo;
    logic [W-1:0]     e_hx;

    task automatic model_reset();
        m_mode = 0; t = 0; m_ref = 0; m_coms = 0; m_lane = 0; m_loss = 0;
        m_win = '0; e_do = '0; e_vo = '0; e_hx = '0;
    endtask

    // Expected outputs after the coming edge, from the bits received so far.
    task automatic model_step();
        e_vo = '0;
        if (m_mode == 0) begin
            if (m_win == COM) begin
                m_ref  = t - 1;
                m_coms = 1;
                m_mode = (CC == 1) ? 2 : 1;
            end
        end else if ((t - 1 > m_ref) && (((t - 1 - m_ref) % W) == 0)) begin
            if (m_mode == 1) begin
                if (m_win == COM) begin
                    m_coms++;
                    if (m_coms == CC) begin
                        m_mode = 2;
                        m_loss = 0;
                    end
                end else begin
                    m_mode = 0;
                    m_coms = 0;
                end
            end else begin
                if (m_win == COM) begin
                    m_lane = 0;
                    m_loss = 0;
                end else begin
                    if (m_win != IDL) begin
                        e_do[m_lane*W +: W] = m_win;
                        e_vo[m_lane]        = 1'b1;
                        e_hx                = m_win;
                        m_lane              = (m_lane + 1) % LANES;
                    end
`ifdef PHY_RX_LOSS_EN
                    if (m_loss == LL - 1) begin
                        m_mode = 0; m_coms = 0; m_lane = 0; m_loss = 0;
                    end else begin
                        m_loss++;
                    end
`endif
                end
            end
        end
    endtask

    // One clock: drive bit/reset, then compare every output with the model.
    task automatic cyc(input logic b, input logic r);
        if (r) model_reset();
        else   model_step();
        default_values = r;
        data_in        = b;
        @(posedge clk_32f);
        #1;
        if (!r) begin
            m_win = {m_win[W-2:0], b};
            t++;
        end
        check("cycle", {18'd0, active, valid, valid_out, data_hexa, data_out},
                       {18'd0, (m_mode == 2), |e_vo, e_vo, e_hx, e_do});
    endtask

    task automatic send_bits(input logic [7:0] v, input int from);
        for (int i = from; i >= 0; i--) cyc(v[i], 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_bits(v, W - 1);
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       rst_before;
        logic [7:0] b;
        logic [3:0] vo;     // valid_out pulse one edge after the byte's last bit
        logic       act;
        logic [7:0] hx;
    } vec_t;

    vec_t vt [NV];

    function automatic vec_t mk(input logic r, input logic [7:0] b, input logic [3:0] vo,
                                input logic a, input logic [7:0] hx);
        vec_t v;
        v.rst_before = r; v.b = b; v.vo = vo; v.act = a; v.hx = hx;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic       pre;
        logic       nb;
        int         r;

        // failed lock: COM run broken by 0x00, then a full run
        vt[0]  = mk(1, 8'hBC, 4'h0, 0, 8'h00);
        vt[1]  = mk(0, 8'hBC, 4'h0, 0, 8'h00);
        vt[2]  = mk(0, 8'hBC, 4'h0, 0, 8'h00);
        vt[3]  = mk(0, 8'h00, 4'h0, 0, 8'h00);
        vt[4]  = mk(0, 8'hBC, 4'h0, 0, 8'h00);
        vt[5]  = mk(0, 8'hBC, 4'h0, 0, 8'h00);
        vt[6]  = mk(0, 8'hBC, 4'h0, 0, 8'h00);
        vt[7]  = mk(0, 8'hBC, 4'h0, 1, 8'h00);
        vt[8]  = mk(0, 8'h5A, 4'h1, 1, 8'h5A);
        // lock at random offset, round-robin, filler and resync
        vt[9]  = mk(1, 8'hBC, 4'h0, 0, 8'h00);
        vt[10] = mk(0, 8'hBC, 4'h0, 0, 8'h00);
        vt[11] = mk(0, 8'hBC, 4'h0, 0, 8'h00);
        vt[12] = mk(0, 8'hBC, 4'h0, 1, 8'h00);
        vt[13] = mk(0, 8'h11, 4'h1, 1, 8'h11);
        vt[14] = mk(0, 8'h22, 4'h2, 1, 8'h22);
        vt[15] = mk(0, 8'h33, 4'h4, 1, 8'h33);
        vt[16] = mk(0, 8'h44, 4'h8, 1, 8'h44);
        vt[17] = mk(0, 8'h55, 4'h1, 1, 8'h55);
        vt[18] = mk(0, 8'hBC, 4'h0, 1, 8'h55);
        vt[19] = mk(0, 8'hA1, 4'h1, 1, 8'hA1);
        vt[20] = mk(0, 8'h7C, 4'h0, 1, 8'hA1);
        vt[21] = mk(0, 8'hA2, 4'h2, 1, 8'hA2);
        vt[22] = mk(0, 8'hBC, 4'h0, 1, 8'hA2);
        vt[23] = mk(0, 8'hA3, 4'h1, 1, 8'hA3);

        model_reset();
        pre = 1'b0;
        for (int i = 0; i < NV; i++) begin
            if (vt[i].rst_before) begin
                for (int k = 0; k < 3; k++) cyc(1'($urandom), 1'b1);
                check("reset_outputs", {18'd0, active, valid, valid_out, data_hexa, data_out}, 64'd0);
                for (int k = 0; k < 3; k++) cyc(1'($urandom), 1'b0);
                pre = 1'b0;
            end
            send_bits(vt[i].b, pre ? W - 2 : W - 1);
            // One more edge (first bit of the next byte) to see the byte's result.
            nb  = 1'b0;
            pre = 1'b0;
            if (i < NV - 1) begin
                if (!vt[i+1].rst_before) begin
                    nb  = vt[i+1].b[W-1];
                    pre = 1'b1;
                end
            end
            cyc(nb, 1'b0);
            check("vec_valid_out", {60'd0, valid_out}, {60'd0, vt[i].vo});
            check("vec_active", {63'd0, active}, {63'd0, vt[i].act});
            check("vec_hexa", {56'd0, data_hexa}, {56'd0, vt[i].hx});
        end
        check("lanes_after_resync", {32'd0, data_out}, 64'h0000_0000_4433_A2A3);

        // reset between data bytes, then a fresh lock is needed
        cyc(1'($urandom), 1'b1);
        check("midreset_outputs", {18'd0, active, valid, valid_out, data_hexa, data_out}, 64'd0);
        send_byte(COM); send_byte(COM); send_byte(COM); send_byte(8'h66);
        cyc(1'b1, 1'b0);
        check("midreset_no_lock", {63'd0, active}, 64'd0);
        check("midreset_no_data", {32'd0, data_out}, 64'd0);
        send_bits(COM, W - 2); send_byte(COM); send_byte(COM); send_byte(COM);
        send_byte(8'h77);
        cyc(1'b1, 1'b0);
        check("relock_lane0_vo", {60'd0, valid_out}, 64'h1);
        check("relock_data", {32'd0, data_out}, 64'h77);

        // 8 data bytes with no COM after a resync
        send_bits(COM, W - 2);
        for (int k = 1; k <= 8; k++) send_byte(8'h80 + 8'(k));
        cyc(1'b0, 1'b0);
        check("loss_8th_delivered", {60'd0, valid_out}, 64'h8);
        check("loss_8th_hexa", {56'd0, data_hexa}, 64'h88);
`ifdef PHY_RX_LOSS_EN
        check("loss_active", {63'd0, active}, 64'd0);
`else
        check("loss_active", {63'd0, active}, 64'd1);
`endif

        // randomized stream against the model
        cyc(1'b0, 1'b1);
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                cyc(1'($urandom), 1'b1);
            end else if (r < 40) begin
                int burst;
                burst = $urandom_range(1, 5);
                for (int k = 0; k < burst; k++) send_byte(COM);
            end else if (r < 52) begin
                send_byte(IDL);
            end else if (r < 92) begin
                send_byte(8'($urandom));
            end else begin
                int slip;
                slip = $urandom_range(1, 3);
                for (int k = 0; k < slip; k++) cyc(1'($urandom), 1'b0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
